prog_counter_core: RTL and testbench

- Programmable, handshaked counter engine; successor to the fixed-STOP counter datapath in the AXI counter IP.
- Adds a run-time terminal value, up/down direction, one-shot or auto-reload mode, an external tick enable, abort, and overrun detection.
- Sits between the AXI-Lite register slice (config, start/ack strobes) and the interrupt/status logic.

---
 rtl/prog_counter_pkg.sv | 8 +
 rtl/prog_counter_core.sv | 83 ++++++++
 tb/tb_prog_counter_core.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/prog_counter_pkg.sv
// prog_counter_pkg: shared state encoding and config constants for the programmable counter
package prog_counter_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic DIR_UP       = 1'b0;
  localparam logic DIR_DOWN     = 1'b1;
  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;
endpackage

// File: rtl/prog_counter_core.sv
// prog_counter_core: handshaked up/down counter with run-time terminal value, reload and overrun count
module prog_counter_core import prog_counter_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int OVR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             ack,
  input  logic             tick,
  input  logic [WIDTH-1:0] term_val,
  input  logic             dir_down,
  input  logic             reload,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] cnt,
  output logic [OVR_W-1:0] ovr_cnt
);
  state_t state, state_nx;
  logic [WIDTH-1:0] term_q, cnt_nx, endpt, load_v;
  logic [OVR_W-1:0] ovr_nx;
  logic dir_q, reload_q, done_nx, accept, term_ev;
  assign accept  = state == IDLE && start && !stop;
  assign endpt   = dir_q == DIR_DOWN ? '0 : term_q;
  assign load_v  = dir_q == DIR_DOWN ? term_q : '0;
  assign term_ev = tick && cnt == endpt;
  assign busy    = state != IDLE;
  // next state, count, done and overrun; stop outranks everything once running
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    done_nx  = done;
    ovr_nx   = ovr_cnt;
    case (state)
      IDLE: if (accept) begin
        state_nx = RUN;
        cnt_nx   = dir_down == DIR_DOWN ? term_val : '0;
        done_nx  = 1'b0;
        ovr_nx   = '0;
      end
      RUN: if (stop) begin
        state_nx = IDLE;
        done_nx  = 1'b0;
      end else if (term_ev) begin
        done_nx = 1'b1;
        if (done && !ack && !(&ovr_cnt)) ovr_nx = ovr_cnt + 1'b1;
        if (reload_q == MODE_RELOAD) cnt_nx = load_v;
        else state_nx = DONE;
      end else begin
        if (tick) cnt_nx = dir_q == DIR_DOWN ? cnt - 1'b1 : cnt + 1'b1;
        if (ack) done_nx = 1'b0;
      end
      DONE: if (stop || ack) begin
        state_nx = IDLE;
        done_nx  = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
  end
  // state/datapath registers; config is captured only on an accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      done     <= 1'b0;
      ovr_cnt  <= '0;
      term_q   <= '0;
      dir_q    <= 1'b0;
      reload_q <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      done    <= done_nx;
      ovr_cnt <= ovr_nx;
      if (accept) begin
        term_q   <= term_val;
        dir_q    <= dir_down;
        reload_q <= reload;
      end
    end
  end
endmodule

// File: tb/tb_prog_counter_core.sv
// tb_prog_counter_core: table, directed and random checks of prog_counter_core against a behavioural model
module tb_prog_counter_core;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 0, stop = 0, ack = 0, tick = 0, dir_down = 0, reload = 0;
  logic [15:0] term_val = '0;
  logic busy, done, busy2, done2;
  logic [15:0] cnt, cnt2;
  logic [7:0] ovr_cnt;
  logic [1:0] ovr2;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  prog_counter_core #(.WIDTH(16), .OVR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .ack(ack), .tick(tick),
    .term_val(term_val), .dir_down(dir_down), .reload(reload),
    .busy(busy), .done(done), .cnt(cnt), .ovr_cnt(ovr_cnt));

  prog_counter_core #(.WIDTH(16), .OVR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .ack(ack), .tick(tick),
    .term_val(term_val), .dir_down(dir_down), .reload(reload),
    .busy(busy2), .done(done2), .cnt(cnt2), .ovr_cnt(ovr2));

  // reference model: mode 0 idle, 1 counting, 2 holding after a one-shot finish
  int m_mode, m_cnt, m_ovr, m_ovr2, m_term;
  bit m_done, m_down, m_rel;

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_done = 0; m_ovr = 0; m_ovr2 = 0;
    m_term = 0; m_down = 0; m_rel = 0;
  endtask

  task automatic model_step();
    int goal;
    if (m_mode == 0) begin
      if (start && !stop) begin
        m_term = int'(term_val); m_down = dir_down; m_rel = reload;
        m_cnt = m_down ? m_term : 0;
        m_done = 0; m_ovr = 0; m_ovr2 = 0; m_mode = 1;
      end
    end else if (stop) begin
      m_mode = 0; m_done = 0;
    end else if (m_mode == 2) begin
      if (ack) begin m_mode = 0; m_done = 0; end
    end else begin
      goal = m_down ? 0 : m_term;
      if (tick && m_cnt == goal) begin
        if (m_done && !ack) begin
          m_ovr = (m_ovr + 1 > 255) ? 255 : m_ovr + 1;
          m_ovr2 = (m_ovr2 + 1 > 3) ? 3 : m_ovr2 + 1;
        end
        m_done = 1;
        if (m_rel) m_cnt = m_down ? m_term : 0;
        else m_mode = 2;
      end else begin
        if (tick) m_cnt = m_down ? m_cnt - 1 : m_cnt + 1;
        if (ack) m_done = 0;
      end
    end
  endtask

  task automatic chk(string nm, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(bit st, bit sp, bit ak, bit tk, int tv, bit dn, bit rl);
    start = st; stop = sp; ack = ak; tick = tk;
    term_val = 16'(tv); dir_down = dn; reload = rl;
  endtask

  // one clock: model follows the edge, outputs sampled 1ns later
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("busy", busy, m_mode != 0);
    chk("done", done, m_done);
    chk("cnt", cnt, m_cnt);
    chk("ovr", ovr_cnt, m_ovr);
    chk("ovr_w2", ovr2, m_ovr2);
  endtask

  typedef struct packed {
    logic st, sp, ak, tk;
    logic [15:0] tv;
    logic dn, rl, eb, ed;
    logic [15:0] ec;
  } vec_t;

  function automatic vec_t mk(bit st, bit sp, bit ak, bit tk, int tv, bit dn, bit rl, bit eb, bit ed, int ec);
    vec_t v;
    v.st = st; v.sp = sp; v.ak = ak; v.tk = tk; v.tv = 16'(tv);
    v.dn = dn; v.rl = rl; v.eb = eb; v.ed = ed; v.ec = 16'(ec);
    return v;
  endfunction

  vec_t tbl[12];

  initial begin
    tbl[0]  = mk(1, 0, 0, 1,  3, 0, 0, 1, 0, 0);
    tbl[1]  = mk(0, 0, 0, 1,  9, 1, 1, 1, 0, 1);
    tbl[2]  = mk(0, 0, 0, 1,  9, 1, 1, 1, 0, 2);
    tbl[3]  = mk(1, 0, 0, 1,  9, 1, 1, 1, 0, 3);
    tbl[4]  = mk(0, 0, 0, 1,  9, 1, 1, 1, 1, 3);
    tbl[5]  = mk(0, 0, 0, 1,  9, 1, 1, 1, 1, 3);
    tbl[6]  = mk(0, 0, 1, 1,  9, 1, 1, 0, 0, 3);
    tbl[7]  = mk(1, 1, 0, 1,  5, 0, 0, 0, 0, 3);
    tbl[8]  = mk(0, 0, 0, 1,  5, 0, 0, 0, 0, 3);
    tbl[9]  = mk(1, 0, 0, 0,  0, 1, 0, 1, 0, 0);
    tbl[10] = mk(0, 0, 0, 1,  7, 0, 1, 1, 1, 0);
    tbl[11] = mk(0, 0, 1, 0,  7, 0, 1, 0, 0, 0);

    model_reset();
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_ovr", ovr_cnt, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].st, tbl[i].sp, tbl[i].ak, tbl[i].tk, int'(tbl[i].tv), tbl[i].dn, tbl[i].rl);
      cyc();
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].eb);
      chk($sformatf("tbl%0d_done", i), done, tbl[i].ed);
      chk($sformatf("tbl%0d_cnt", i), cnt, tbl[i].ec);
      chk($sformatf("tbl%0d_ovr", i), ovr_cnt, 0);
    end

    // reload down from 2, ack whenever done is high
    drive(1, 0, 0, 1, 2, 1, 1); cyc();
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, m_done, 1, 0, 0, 0); cyc();
      chk("rld_dn_cnt", cnt, (i % 3 == 0) ? 1 : (i % 3 == 1) ? 0 : 2);
      chk("rld_dn_done", done, i % 3 == 2);
    end
    chk("rld_dn_ovr", ovr_cnt, 0);
    drive(0, 1, 0, 0, 0, 0, 0); cyc();

    // reload up to 1, never ack: six terminal events
    drive(1, 0, 0, 1, 1, 0, 1); cyc();
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 0, 1, 0, 0, 0); cyc();
    end
    chk("ovr_done", done, 1);
    chk("ovr_8b", ovr_cnt, 5);
    chk("ovr_2b_sat", ovr2, 3);
    drive(0, 1, 0, 0, 0, 0, 0); cyc();
    chk("stop_keeps_ovr", ovr_cnt, 5);

    // gated tick, one-shot up to 2
    drive(1, 0, 0, 0, 2, 0, 0); cyc();
    drive(0, 0, 0, 1, 0, 0, 0); cyc();
    drive(0, 0, 0, 0, 0, 0, 0); cyc(); cyc();
    chk("gate_hold_cnt", cnt, 1);
    drive(0, 0, 0, 1, 0, 0, 0); cyc();
    drive(0, 0, 0, 0, 0, 0, 0); cyc();
    chk("gate_no_done", done, 0);
    drive(0, 0, 0, 1, 0, 0, 0); cyc();
    chk("gate_done", done, 1);
    drive(0, 0, 1, 0, 0, 0, 0); cyc();

    // stop mid-run at cnt=5
    drive(1, 0, 0, 1, 10, 0, 0); cyc();
    drive(0, 0, 0, 1, 0, 0, 0);
    repeat (5) cyc();
    drive(0, 1, 0, 1, 0, 0, 0); cyc();
    chk("stop_busy", busy, 0);
    chk("stop_done", done, 0);
    chk("stop_cnt", cnt, 5);

    // stop coincident with terminal event
    drive(1, 0, 0, 1, 1, 0, 0); cyc();
    drive(0, 0, 0, 1, 0, 0, 0); cyc();
    drive(0, 1, 0, 1, 0, 0, 0); cyc();
    chk("stop_term_done", done, 0);
    chk("stop_term_cnt", cnt, 1);

    // all-ones terminal counting down
    drive(1, 0, 0, 0, 65535, 1, 0); cyc();
    chk("max_load", cnt, 65535);
    drive(0, 0, 0, 1, 0, 0, 0); cyc();
    chk("max_dec", cnt, 65534);
    drive(0, 1, 0, 0, 0, 0, 0); cyc();

    // start during run ignored, then async reset between edges
    drive(1, 0, 0, 1, 10, 0, 0); cyc();
    drive(0, 0, 0, 1, 3, 1, 1); cyc(); cyc();
    drive(1, 0, 0, 1, 2, 1, 0); cyc();
    chk("restart_ignored", cnt, 3);
    drive(0, 0, 0, 1, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_cnt", cnt, 0);
    chk("arst_done", done, 0);
    chk("arst_ovr", ovr_cnt, 0);
    model_reset();
    #1 rst_n = 1'b1;

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 40) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) != 0, ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(0, 9)),
            1'($urandom), 1'($urandom));
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
